// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes,
// FSM state encoding and default widths.
package md_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 6;

    localparam logic [1:0] M_GRP = 2'b01;

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/md_sequencer_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. Accumulator layout is {hi/remainder[XLEN:0], lo/quotient[XLEN-1:0]}.
module md_step
    import md_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic              i_div,
    input  logic [2*XLEN:0]   i_acc,
    input  logic [XLEN-1:0]   i_operand,
    output logic [2*XLEN:0]   o_acc,
    output logic              o_qbit
);

    logic [XLEN:0]   w_hi;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_hi    = i_acc[2*XLEN:XLEN];
        w_sum   = w_hi + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_shift = {w_hi[XLEN-1:0], i_acc[XLEN-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, i_operand};
        // Borrow out of the widened subtract means shifted remainder < divisor
        w_ge    = ~w_diff[XLEN+1];
        o_qbit  = i_div & w_ge;
        // Divide leaves the new quotient slot clear; the caller merges o_qbit
        if (i_div) begin
            o_acc = {(w_ge ? w_diff[XLEN:0] : w_shift), i_acc[XLEN-2:0], 1'b0};
        end else begin
            o_acc = {1'b0, w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// RV32M multi-cycle sequencer: latches an M-op, strips signs, iterates md_step
// XLEN times, fixes up sign and selects the result, then pulses result_valid.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int unsigned ACC_W = 2 * XLEN + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_opnd;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_mul_hi;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special_val;
    logic [ACC_W-1:0]  w_step_acc;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_sel;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_fix_val;

    assign w_accept = (r_state == ST_IDLE) & start & (aluop[4:3] == M_GRP);

    // Op decode, operand magnitudes and special-case detection
    always_comb begin
        w_is_div = r_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        w_is_rem = r_op inside {ALU_REM, ALU_REMU};
        w_mul_hi = r_op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU};
        w_sa     = r_a[XLEN-1] & (r_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        w_sb     = r_b[XLEN-1] & (r_op inside {ALU_MULH, ALU_DIV, ALU_REM});
        w_a_mag  = w_sa ? -r_a : r_a;
        w_b_mag  = w_sb ? -r_b : r_b;
        w_neg    = w_is_rem ? w_sa : (w_sa ^ w_sb);
        w_div0   = w_is_div & (r_b == '0);
        w_ovf    = (r_op inside {ALU_DIV, ALU_REM}) & (r_a == INT_MIN) & (r_b == '1);
        if (w_div0) begin
            w_special_val = w_is_rem ? r_a : '1;
        end else begin
            w_special_val = w_is_rem ? '0 : r_a;
        end
    end

    md_step #(.XLEN(XLEN)) u_step (
        .i_div     (w_is_div),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_step_acc),
        .o_qbit    (w_qbit)
    );

    // Sign fix-up and result selection
    always_comb begin
        w_prod_fix = r_neg ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
        w_div_sel  = w_is_rem ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
        w_div_fix  = r_neg ? -w_div_sel : w_div_sel;
        if (w_is_div) begin
            w_fix_val = w_div_fix;
        end else if (w_mul_hi) begin
            w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
        end else begin
            w_fix_val = w_prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_op    <= aluop;
                            r_a     <= operand_a;
                            r_b     <= operand_b;
                            r_busy  <= 1'b1;
                            r_state <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        r_neg  <= w_neg;
                        r_cnt  <= CNT_W'(XLEN);
                        r_acc  <= {{(XLEN+1){1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                        if (w_div0 | w_ovf) begin
                            r_result <= w_special_val;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        r_acc <= w_step_acc | ACC_W'(w_qbit);
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_result <= w_fix_val;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign stall        = w_accept | (r_state inside {ST_PREP, ST_CALC, ST_FIX});
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the single-cycle ALU. The pipeline hands it an M-extension AlUop and two operands.
- It stalls the front of the pipeline until the result is ready, then returns a 1-cycle result pulse.
- It runs one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) and sequences sign handling and RISC-V special cases.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; ignored unless aluop[4:3]==2'b01.
- aluop  in  5  01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- operand_a  in  XLEN  rs1 value (multiplicand / dividend).
- operand_b  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  abort current operation (branch/jump squash).
- stall  out  1  holds the IF/ID/EX pipeline registers.
- busy  out  1  high in any state other than IDLE.
- result  out  XLEN  final value; valid only while result_valid=1.
- result_valid  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous): state=IDLE. Counter, accumulators, result, result_valid, busy all 0.
- Operand and op latch: aluop and operands are captured in IDLE on the cycle where start=1 and the op is M-class. Inputs are ignored afterwards.
- State IDLE:
  - Accepted start -> PREP.
  - Non-M aluop with start=1 -> stay in IDLE.
- State PREP (1 cycle):
  - Compute operand magnitudes. Signed: MULH, DIV, REM for both operands; MULHSU for operand_a only.
  - Record neg_result:
    - MUL*: sign_a XOR sign_b (signed operands only).
    - DIV: sign_a XOR sign_b.
    - REM: sign_a.
  - Clear the accumulator and load counter=XLEN.
  - Special cases go straight to DONE with the result preloaded:
    - divisor==0 for DIV/DIVU: result = all ones.
    - divisor==0 for REM/REMU: result = operand_a.
    - DIV with a=0x80000000, b=0xFFFFFFFF: result = 0x80000000.
    - REM with the same operands: result = 0.
  - Otherwise -> CALC.
- State CALC (XLEN cycles):
  - One bit per cycle; counter decrements.
  - Multiply: 2*XLEN product register, shift-add.
  - Divide: restoring step; quotient bit = 1 when partial remainder >= divisor.
  - Counter reaching 1 on the current step -> FIX.
- State FIX (1 cycle):
  - Negate (two's complement) if neg_result.
  - Select the result:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV*: quotient.
    - REM*: remainder.
  - -> DONE.
- State DONE (1 cycle):
  - result_valid=1, stall=0, busy=1.
  - -> IDLE unconditionally.
  - A start in DONE is not accepted; it must be re-presented in IDLE.
- stall (combinational) = (state==IDLE & start & M-op) | state∈{PREP, CALC, FIX}. There is no combinational path from stall back to start.
- Latency, start cycle to result_valid cycle inclusive:
  - Normal: XLEN+4 = 36 cycles.
  - Special case: 3 cycles.
- result holds its last value after DONE until the next FIX or special-case load.
- flush has priority over everything except reset:
  - Any state -> IDLE next cycle. No result_valid; the result register is unchanged.
  - flush together with start in IDLE: the request is not accepted.
- Reset mid-operation: immediate return to reset values on the next edge; no pulse.
- All arithmetic is unsigned on the magnitudes. The product register is 2*XLEN wide and the remainder register XLEN+1 wide, so there is no overflow.

Decomposition:
- Shared package md_pkg:
  - AlUop localparams for the 8 M ops (shared with controlUnit).
  - State encoding: IDLE, PREP, CALC, FIX, DONE (3-bit).
  - XLEN default.
- One sub-module, md_step: combinational single-iteration shift-add / shift-subtract.
  - Inputs: mode, accumulator, divisor/multiplicand.
  - Outputs: next accumulator and quotient bit.
  - The FSM, counter and sign logic stay in md_sequencer.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> result=0xFFFFFFEB. result_valid exactly 36 cycles after start. stall high for cycles 1-35, low on cycle 36.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU same -> 2.
- Special cases, each pulsing on cycle 3:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000.
  - REM same -> 0.
- flush asserted on CALC cycle 10 -> IDLE next cycle, no result_valid; a following DIVU 9/2 completes with result 4.
- Sequencing and reset:
  - start with aluop=00000 (ADD) -> no stall, stays in IDLE.
  - Back-to-back M starts -> second accepted only in IDLE after DONE.
  - reset mid-CALC -> all outputs 0 next cycle.
